button_pulse_conditioner: RTL and testbench

Converts two raw, asynchronous push-button levels (count-up, count-down) into clean single-cycle `up`/`down`/`enable` pulses for the 3-bit up/down counter stage directly downstream. Each button gets a synchroniser, a debouncer, press-edge detection and optional hold-to-auto-repeat. A chord lockout ensures the counter never sees `up` and `down` together.

---
 rtl/button_pulse_conditioner.sv | 127 ++++++++++++
 tb/tb_button_pulse_conditioner.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/button_pulse_conditioner.sv
// rtl/button_pulse_conditioner.sv - two-button synchronise/debounce/auto-repeat pulse generator
// Index 0 is the up button, index 1 the down button throughout.
module button_pulse_conditioner #(
  parameter int unsigned DB_COUNT      = 500000,
  parameter int unsigned DB_WIDTH      = 19,
  parameter bit          REPEAT_EN     = 1'b1,
  parameter int unsigned REPEAT_DELAY  = 25000000,
  parameter int unsigned REPEAT_PERIOD = 10000000,
  parameter int unsigned RPT_WIDTH     = 25
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_up_raw,
  input  logic btn_down_raw,
  output logic up,
  output logic down,
  output logic enable
);

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} rpt_state_t;

  localparam logic [DB_WIDTH-1:0]  DB_LAST     = DB_WIDTH'(DB_COUNT - 1);
  localparam logic [RPT_WIDTH-1:0] DELAY_LAST  = RPT_WIDTH'(REPEAT_DELAY - 1);
  localparam logic [RPT_WIDTH-1:0] PERIOD_LAST = RPT_WIDTH'(REPEAT_PERIOD - 1);

  logic [1:0]           raw;
  logic [1:0]           s1;
  logic [1:0]           s2;
  logic [1:0]           db;
  logic [1:0]           db_d;
  logic [DB_WIDTH-1:0]  dbc [2];
  rpt_state_t           state [2];
  rpt_state_t           state_next [2];
  logic [RPT_WIDTH-1:0] rc [2];
  logic [RPT_WIDTH-1:0] rc_next [2];
  logic [1:0]           press;
  logic [1:0]           evt;
  logic                 up_keep;
  logic                 down_keep;

  assign raw   = {btn_down_raw, btn_up_raw};
  assign press = db & ~db_d;
  // Chord lockout: an event survives only while the other button is debounced-released.
  assign up_keep   = evt[0] & ~db[1];
  assign down_keep = evt[1] & ~db[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      s1     <= '0;
      s2     <= '0;
      db     <= '0;
      db_d   <= '0;
      up     <= 1'b0;
      down   <= 1'b0;
      enable <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        dbc[i]   <= '0;
        state[i] <= IDLE;
        rc[i]    <= '0;
      end
    end else begin
      s1     <= raw;
      s2     <= s1;
      db_d   <= db;
      up     <= up_keep;
      down   <= down_keep;
      enable <= up_keep | down_keep;
      for (int i = 0; i < 2; i++) begin
        if (s2[i] == db[i]) begin
          dbc[i] <= '0;
        end else if (dbc[i] == DB_LAST) begin
          db[i]  <= s2[i];
          dbc[i] <= '0;
        end else begin
          dbc[i] <= dbc[i] + DB_WIDTH'(1);
        end
        state[i] <= state_next[i];
        rc[i]    <= rc_next[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      state_next[i] = state[i];
      rc_next[i]    = rc[i];
      evt[i]        = 1'b0;
      case (state[i])
        IDLE: begin
          if (press[i]) begin
            evt[i]        = 1'b1;
            rc_next[i]    = '0;
            state_next[i] = REPEAT_EN ? HOLD : IDLE;
          end
        end
        HOLD: begin
          if (!db[i]) begin
            state_next[i] = IDLE;
            rc_next[i]    = '0;
          end else if (rc[i] == DELAY_LAST) begin
            evt[i]        = 1'b1;
            rc_next[i]    = '0;
            state_next[i] = REPEAT;
          end else begin
            rc_next[i] = rc[i] + RPT_WIDTH'(1);
          end
        end
        REPEAT: begin
          if (!db[i]) begin
            state_next[i] = IDLE;
            rc_next[i]    = '0;
          end else if (rc[i] == PERIOD_LAST) begin
            evt[i]     = 1'b1;
            rc_next[i] = '0;
          end else begin
            rc_next[i] = rc[i] + RPT_WIDTH'(1);
          end
        end
        default: begin
          state_next[i] = IDLE;
          rc_next[i]    = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_pulse_conditioner.sv
// tb/tb_button_pulse_conditioner.sv - scoreboard bench for button_pulse_conditioner
// Expected pulses are queued as (edge number, instance, direction); monitor pops on every pulse.
module tb_button_pulse_conditioner;

  typedef struct {
    int   cyc;
    int   dut;
    logic is_up;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic up_raw = 1'b1;
  logic dn_raw = 1'b1;
  logic up1_raw = 1'b0;
  logic dn1_raw = 1'b0;
  logic up0, down0, en0;
  logic up1, down1, en1;

  int   cyc = 0;
  int   tests_run = 0;
  int   tests_failed = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  button_pulse_conditioner #(
    .DB_COUNT(4), .DB_WIDTH(3), .REPEAT_EN(1'b1),
    .REPEAT_DELAY(20), .REPEAT_PERIOD(8), .RPT_WIDTH(5)
  ) dut0 (
    .clk(clk), .reset(reset), .btn_up_raw(up_raw), .btn_down_raw(dn_raw),
    .up(up0), .down(down0), .enable(en0)
  );

  button_pulse_conditioner #(
    .DB_COUNT(4), .DB_WIDTH(3), .REPEAT_EN(1'b0),
    .REPEAT_DELAY(20), .REPEAT_PERIOD(8), .RPT_WIDTH(5)
  ) dut1 (
    .clk(clk), .reset(reset), .btn_up_raw(up1_raw), .btn_down_raw(dn1_raw),
    .up(up1), .down(down1), .enable(en1)
  );

  task automatic expect_pulse(input int dut, input int at, input logic is_up);
    exp_t e;
    e.cyc   = at;
    e.dut   = dut;
    e.is_up = is_up;
    exp_q.push_back(e);
  endtask

  function automatic int find_first(input int dut);
    for (int i = 0; i < exp_q.size(); i++)
      if (exp_q[i].dut == dut) return i;
    return -1;
  endfunction

  task automatic check_pulse(input int dut, input logic u, input logic d, input logic e);
    int idx;
    tests_run++;
    if (e !== (u | d) || (u & d) !== 1'b0) begin
      tests_failed++;
      $display("FAIL invariant dut%0d edge %0d: up=%b down=%b enable=%b, required enable=up|down and not both",
               dut, cyc, u, d, e);
    end
    idx = find_first(dut);
    while (idx >= 0 && exp_q[idx].cyc < cyc) begin
      tests_run++;
      tests_failed++;
      $display("FAIL missed_pulse dut%0d: not observed, required %s pulse at edge %0d",
               dut, exp_q[idx].is_up ? "up" : "down", exp_q[idx].cyc);
      exp_q.delete(idx);
      idx = find_first(dut);
    end
    if (u === 1'b1 || d === 1'b1) begin
      tests_run++;
      if (idx < 0) begin
        tests_failed++;
        $display("FAIL unexpected_pulse dut%0d: up=%b down=%b at edge %0d, required none", dut, u, d, cyc);
      end else begin
        if (exp_q[idx].cyc != cyc || u !== exp_q[idx].is_up || d !== !exp_q[idx].is_up) begin
          tests_failed++;
          $display("FAIL pulse dut%0d: up=%b down=%b at edge %0d, required %s at edge %0d",
                   dut, u, d, cyc, exp_q[idx].is_up ? "up" : "down", exp_q[idx].cyc);
        end
        exp_q.delete(idx);
      end
    end
  endtask

  always @(negedge clk) begin
    check_pulse(0, up0, down0, en0);
    check_pulse(1, up1, down1, en1);
  end

  task automatic check_zero(input string name);
    tests_run++;
    if ({up0, down0, en0, up1, down1, en1} !== 6'b0) begin
      tests_failed++;
      $display("FAIL %s edge %0d: outputs=%b%b%b/%b%b%b, required all 0",
               name, cyc, up0, down0, en0, up1, down1, en1);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int e;
    // Reset held for three edges with both buttons pressed.
    for (int i = 0; i < 3; i++) begin
      step(1);
      check_zero("reset_hold");
    end
    reset  = 1'b0;
    dn_raw = 1'b0;
    expect_pulse(0, cyc + 7, 1'b1);
    step(10);
    up_raw = 1'b0;
    step(20);

    // Clean press, no pulse on release.
    up_raw = 1'b1;
    expect_pulse(0, cyc + 7, 1'b1);
    step(10);
    up_raw = 1'b0;
    step(20);

    // Bounce on down: 1,0,1,0 then steady 1.
    dn_raw = 1'b1; step(1);
    dn_raw = 1'b0; step(1);
    dn_raw = 1'b1; step(1);
    dn_raw = 1'b0; step(1);
    dn_raw = 1'b1;
    expect_pulse(0, cyc + 7, 1'b0);
    step(10);
    dn_raw = 1'b0;
    step(20);

    // Auto-repeat: press pulse at P, repeats at P+20, +28, +36, +44, +52.
    e = cyc;
    up_raw = 1'b1;
    expect_pulse(0, e + 7, 1'b1);
    for (int k = 20; k <= 52; k += 8) expect_pulse(0, e + 7 + k, 1'b1);
    step(57);
    up_raw = 1'b0;
    step(30);

    // Auto-repeat disabled: one pulse despite a long hold.
    up1_raw = 1'b1;
    expect_pulse(1, cyc + 7, 1'b1);
    step(40);
    up1_raw = 1'b0;
    step(20);

    // Simultaneous press: everything locked out.
    up_raw = 1'b1;
    dn_raw = 1'b1;
    step(30);
    up_raw = 1'b0;
    dn_raw = 1'b0;
    step(20);

    // Down held, then up chorded in: up dropped, down repeats masked until up is released.
    e = cyc;
    dn_raw = 1'b1;
    expect_pulse(0, e + 7, 1'b0);
    step(10);
    up_raw = 1'b1;
    step(30);
    up_raw = 1'b0;
    expect_pulse(0, e + 51, 1'b0);
    step(12);
    dn_raw = 1'b0;
    step(25);

    // Reset landing on the edge where a repeat pulse (e+43) was due.
    e = cyc;
    up_raw = 1'b1;
    expect_pulse(0, e + 7, 1'b1);
    expect_pulse(0, e + 27, 1'b1);
    expect_pulse(0, e + 35, 1'b1);
    step(42);
    reset = 1'b1;
    step(1);
    check_zero("reset_mid_repeat");
    step(1);
    check_zero("reset_mid_repeat_hold");
    reset = 1'b0;
    expect_pulse(0, cyc + 7, 1'b1);
    step(10);
    up_raw = 1'b0;
    step(20);

    while (exp_q.size() > 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL leftover dut%0d: no pulse seen, required %s at edge %0d",
               exp_q[0].dut, exp_q[0].is_up ? "up" : "down", exp_q[0].cyc);
      exp_q.delete(0);
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
